// File: rtl/midi_tx_scheduler.sv
// Message-atomic round-robin scheduler for the MIDI TX byte stream, with real-time
// byte priority and a per-message stall watchdog that aborts and flushes hung messages.
//
//   state   | meaning
//   S_IDLE  | no message owns the sink; arbitrate among eligible sources
//   S_MSG   | granted source streams its message bytes until its last byte
//   S_ABORT | stalled message is terminated with ABORT_BYTE
module midi_tx_scheduler #(
    parameter int         NUM_SRC    = 4,
    parameter int         TIMEOUT    = 1024,
    parameter logic [7:0] ABORT_BYTE = 8'hF7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rt_data,
    input  logic                       rt_valid,
    output logic                       rt_rd,
    input  logic [8*NUM_SRC-1:0]       src_data,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [NUM_SRC-1:0]         src_last,
    output logic [NUM_SRC-1:0]         src_rd,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       out_rd,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic [7:0]                 abort_cnt
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] STALL_LAST = (TIMEOUT > 0) ? SW'(TIMEOUT - 1) : '0;
    localparam logic [GW-1:0] LAST_SRC   = GW'(NUM_SRC - 1);

    typedef enum logic [1:0] {S_IDLE, S_MSG, S_ABORT} state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        rr_q, rr_d;
    logic [SW-1:0]        stall_q, stall_d;
    logic [NUM_SRC-1:0]   flush_q, flush_d;
    logic [7:0]           abort_q, abort_d;

    logic                 found;
    int                   scan_idx;
    logic [7:0]           g_data;
    logic                 g_valid;
    logic                 g_last;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        stall_d   = stall_q;
        flush_d   = flush_q;
        abort_d   = abort_q;
        out_data  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        rt_rd     = 1'b0;
        src_rd    = '0;
        found     = 1'b0;
        scan_idx  = 0;
        g_data    = src_data[8*int'(grant_q) +: 8];
        g_valid   = src_valid[grant_q];
        g_last    = src_last[grant_q];

        // Discard runs regardless of who owns the sink or whether rt is passing.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (flush_q[i]) begin
                src_rd[i] = src_valid[i];
                if (src_valid[i] && src_last[i]) begin
                    flush_d[i] = 1'b0;
                end
            end
        end

        if (rt_valid) begin
            out_data  = rt_data;
            out_valid = 1'b1;
            out_last  = 1'b1;
            rt_rd     = out_rd;
        end else begin
            case (state_q)
                S_IDLE: begin
                    for (int k = 1; k <= NUM_SRC; k++) begin
                        scan_idx = (int'(rr_q) + k) % NUM_SRC;
                        if (!found && src_valid[scan_idx] && !flush_q[scan_idx]) begin
                            found   = 1'b1;
                            grant_d = GW'(scan_idx);
                            state_d = S_MSG;
                            stall_d = '0;
                        end
                    end
                end
                S_MSG: begin
                    out_data        = g_data;
                    out_valid       = g_valid;
                    out_last        = g_last;
                    src_rd[grant_q] = out_rd;
                    if (g_valid && out_rd) begin
                        stall_d = '0;
                        if (g_last) begin
                            rr_d    = grant_q;
                            state_d = S_IDLE;
                        end
                    end else if (TIMEOUT > 0 && !g_valid) begin
                        // Only source starvation counts; sink back-pressure never aborts.
                        if (stall_q == STALL_LAST) begin
                            state_d          = S_ABORT;
                            flush_d[grant_q] = 1'b1;
                            stall_d          = '0;
                        end else begin
                            stall_d = stall_q + 1'b1;
                        end
                    end
                end
                S_ABORT: begin
                    out_data  = ABORT_BYTE;
                    out_valid = 1'b1;
                    out_last  = 1'b1;
                    if (out_rd) begin
                        if (abort_q != 8'hFF) begin
                            abort_d = abort_q + 8'd1;
                        end
                        rr_d    = grant_q;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (rst) begin
            out_valid = 1'b0;
            rt_rd     = 1'b0;
            src_rd    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= LAST_SRC;
            stall_q <= '0;
            flush_q <= '0;
            abort_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
            abort_q <= abort_d;
        end
    end

    assign grant_id  = grant_q;
    assign busy      = (state_q != S_IDLE);
    assign abort_cnt = abort_q;

endmodule

// File: tb/tb_midi_tx_scheduler.sv
// Directed bench for midi_tx_scheduler: a cycle vector table for arbitration and rt
// interleave, followed by hand-written sequences for back-pressure, watchdog and reset.
module tb_midi_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rt_data;
    logic        rt_valid;
    logic        rt_rd;
    logic [31:0] src_data;
    logic [3:0]  src_valid;
    logic [3:0]  src_last;
    logic [3:0]  src_rd;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_rd;
    logic [1:0]  grant_id;
    logic        busy;
    logic [7:0]  abort_cnt;

    int n_total = 0;
    int n_pass  = 0;

    midi_tx_scheduler #(.NUM_SRC(4), .TIMEOUT(16), .ABORT_BYTE(8'hF7)) dut (
        .clk(clk), .rst(rst),
        .rt_data(rt_data), .rt_valid(rt_valid), .rt_rd(rt_rd),
        .src_data(src_data), .src_valid(src_valid), .src_last(src_last), .src_rd(src_rd),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_rd(out_rd),
        .grant_id(grant_id), .busy(busy), .abort_cnt(abort_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sv;
        logic [3:0]  sl;
        logic [31:0] sd;
        logic        rtv;
        logic [7:0]  rtd;
        logic        ord;
        logic        ev;
        logic [7:0]  ed;
        logic        el;
        logic [3:0]  erd;
        logic        ert;
        logic        eb;
        logic [1:0]  eg;
    } vec_t;

    vec_t vec [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] sv, input logic [3:0] sl, input logic [31:0] sd,
                         input logic rtv, input logic [7:0] rtd, input logic ord);
        src_valid = sv;
        src_last  = sl;
        src_data  = sd;
        rt_valid  = rtv;
        rt_data   = rtd;
        out_rd    = ord;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(4'b0, 4'b0, 32'h0, 1'b0, 8'h0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int bad;
        int ng;
        logic [1:0] grants [8];
        logic [7:0] datas  [8];

        // src0: F0 7E F7 / src1: 90 3C, then src2 SysEx with an F8 after 41, then rt in idle.
        vec[0]  = '{4'b0011, 4'b0000, 32'h0000_90F0, 0, 8'h00, 1, 0, 8'h00, 0, 4'b0000, 0, 0, 2'd0};
        vec[1]  = '{4'b0011, 4'b0000, 32'h0000_90F0, 0, 8'h00, 1, 1, 8'hF0, 0, 4'b0001, 0, 1, 2'd0};
        vec[2]  = '{4'b0011, 4'b0000, 32'h0000_907E, 0, 8'h00, 1, 1, 8'h7E, 0, 4'b0001, 0, 1, 2'd0};
        vec[3]  = '{4'b0011, 4'b0001, 32'h0000_90F7, 0, 8'h00, 1, 1, 8'hF7, 1, 4'b0001, 0, 1, 2'd0};
        vec[4]  = '{4'b0010, 4'b0000, 32'h0000_9000, 0, 8'h00, 1, 0, 8'h00, 0, 4'b0000, 0, 0, 2'd0};
        vec[5]  = '{4'b0010, 4'b0000, 32'h0000_9000, 0, 8'h00, 1, 1, 8'h90, 0, 4'b0010, 0, 1, 2'd1};
        vec[6]  = '{4'b0010, 4'b0010, 32'h0000_3C00, 0, 8'h00, 1, 1, 8'h3C, 1, 4'b0010, 0, 1, 2'd1};
        vec[7]  = '{4'b0000, 4'b0000, 32'h0000_0000, 0, 8'h00, 1, 0, 8'h00, 0, 4'b0000, 0, 0, 2'd1};
        vec[8]  = '{4'b0100, 4'b0000, 32'h00F0_0000, 0, 8'h00, 1, 0, 8'h00, 0, 4'b0000, 0, 0, 2'd1};
        vec[9]  = '{4'b0100, 4'b0000, 32'h00F0_0000, 0, 8'h00, 1, 1, 8'hF0, 0, 4'b0100, 0, 1, 2'd2};
        vec[10] = '{4'b0100, 4'b0000, 32'h0041_0000, 0, 8'h00, 1, 1, 8'h41, 0, 4'b0100, 0, 1, 2'd2};
        vec[11] = '{4'b0100, 4'b0000, 32'h0010_0000, 1, 8'hF8, 1, 1, 8'hF8, 1, 4'b0000, 1, 1, 2'd2};
        vec[12] = '{4'b0100, 4'b0000, 32'h0010_0000, 0, 8'h00, 1, 1, 8'h10, 0, 4'b0100, 0, 1, 2'd2};
        vec[13] = '{4'b0100, 4'b0100, 32'h00F7_0000, 0, 8'h00, 1, 1, 8'hF7, 1, 4'b0100, 0, 1, 2'd2};
        vec[14] = '{4'b1000, 4'b1000, 32'h5500_0000, 1, 8'hFE, 1, 1, 8'hFE, 1, 4'b0000, 1, 0, 2'd2};
        vec[15] = '{4'b1000, 4'b1000, 32'h5500_0000, 0, 8'h00, 1, 0, 8'h00, 0, 4'b0000, 0, 0, 2'd2};
        vec[16] = '{4'b1000, 4'b1000, 32'h5500_0000, 0, 8'h00, 1, 1, 8'h55, 1, 4'b1000, 0, 1, 2'd3};
        vec[17] = '{4'b0000, 4'b0000, 32'h0000_0000, 0, 8'h00, 1, 0, 8'h00, 0, 4'b0000, 0, 0, 2'd3};

        // Outputs gated while reset is held, even with traffic present.
        rst = 1'b1;
        drive(4'b1111, 4'b1111, 32'h4433_2211, 1'b1, 8'hF8, 1'b1);
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_rt_rd", 32'(rt_rd), 32'h0);
        chk("rst_src_rd", 32'(src_rd), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        drive(4'b0, 4'b0, 32'h0, 1'b0, 8'h0, 1'b0);
        #2;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_abort_cnt", 32'(abort_cnt), 32'h0);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(vec[i].sv, vec[i].sl, vec[i].sd, vec[i].rtv, vec[i].rtd, vec[i].ord);
            #2;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vec[i].ev));
            if (vec[i].ev) begin
                chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vec[i].ed));
                chk($sformatf("v%0d_out_last", i), 32'(out_last), 32'(vec[i].el));
            end
            chk($sformatf("v%0d_src_rd", i), 32'(src_rd), 32'(vec[i].erd));
            chk($sformatf("v%0d_rt_rd", i), 32'(rt_rd), 32'(vec[i].ert));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vec[i].eb));
            chk($sformatf("v%0d_grant", i), 32'(grant_id), 32'(vec[i].eg));
            tick();
        end

        // All sources stream single-byte messages: strict 0,1,2,3 rotation.
        do_reset();
        drive(4'b1111, 4'b1111, 32'h3322_1100, 1'b0, 8'h0, 1'b1);
        ng = 0;
        for (int c = 0; c < 20; c++) begin
            #2;
            if (out_valid && out_rd && ng < 8) begin
                grants[ng] = grant_id;
                datas[ng]  = out_data;
                ng++;
            end
            tick();
        end
        chk("rr_msg_count", 32'(ng), 32'd8);
        for (int k = 0; k < ng; k++) begin
            chk($sformatf("rr_grant%0d", k), 32'(grants[k]), 32'(k % 4));
            chk($sformatf("rr_data%0d", k), 32'(datas[k]), 32'(8'h11 * (k % 4)));
        end

        // Sink back-pressure for 20 clks mid-message must hold the byte and never abort.
        do_reset();
        drive(4'b0010, 4'b0000, 32'h0000_A500, 1'b0, 8'h0, 1'b1);
        tick();
        #2;
        chk("bp_first_byte", 32'(out_data), 32'hA5);
        tick();
        drive(4'b0010, 4'b0000, 32'h0000_B600, 1'b0, 8'h0, 1'b0);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            #2;
            if (!(out_valid && out_data == 8'hB6 && src_rd == 4'b0 && busy && abort_cnt == 8'd0)) bad++;
            tick();
        end
        chk("bp_hold_bad_cycles", 32'(bad), 32'd0);
        drive(4'b0010, 4'b0010, 32'h0000_B600, 1'b0, 8'h0, 1'b1);
        #2;
        chk("bp_release_data", 32'({out_valid, out_last, out_data}), 32'h3B6);
        chk("bp_release_rd", 32'(src_rd), 32'b0010);
        tick();
        drive(4'b0000, 4'b0000, 32'h0, 1'b0, 8'h0, 1'b1);
        #2;
        chk("bp_idle_busy", 32'(busy), 32'h0);
        chk("bp_abort_cnt", 32'(abort_cnt), 32'h0);

        // Watchdog: src1 sends F0 43 then starves for exactly 16 clks.
        do_reset();
        drive(4'b0010, 4'b0000, 32'h0000_F000, 1'b0, 8'h0, 1'b1);
        tick();
        #2;
        chk("wd_byte0", 32'(out_data), 32'hF0);
        tick();
        drive(4'b0010, 4'b0000, 32'h0000_4300, 1'b0, 8'h0, 1'b1);
        #2;
        chk("wd_byte1", 32'(out_data), 32'h43);
        tick();
        drive(4'b0000, 4'b0000, 32'h0, 1'b0, 8'h0, 1'b1);
        bad = 0;
        for (int c = 0; c < 16; c++) begin
            #2;
            if (out_valid || !busy) bad++;
            tick();
        end
        chk("wd_stall_window", 32'(bad), 32'd0);
        #2;
        chk("wd_abort_byte", 32'({out_valid, out_last, out_data}), 32'h3F7);
        chk("wd_abort_busy", 32'(busy), 32'h1);
        tick();
        // src1 remainder 10 20 F7 is discarded while src0 sends 11 22.
        drive(4'b0011, 4'b0000, 32'h0000_1011, 1'b0, 8'h0, 1'b1);
        #2;
        chk("wd_abort_cnt", 32'(abort_cnt), 32'd1);
        chk("wd_idle_busy", 32'(busy), 32'h0);
        chk("fl_a_out_valid", 32'(out_valid), 32'h0);
        chk("fl_a_src_rd", 32'(src_rd), 32'b0010);
        tick();
        drive(4'b0011, 4'b0000, 32'h0000_2011, 1'b0, 8'h0, 1'b1);
        #2;
        chk("fl_b_out", 32'({out_valid, out_last, out_data}), 32'h211);
        chk("fl_b_grant", 32'(grant_id), 32'd0);
        chk("fl_b_src_rd", 32'(src_rd), 32'b0011);
        tick();
        drive(4'b0011, 4'b0011, 32'h0000_F722, 1'b0, 8'h0, 1'b1);
        #2;
        chk("fl_c_out", 32'({out_valid, out_last, out_data}), 32'h322);
        chk("fl_c_src_rd", 32'(src_rd), 32'b0011);
        tick();
        drive(4'b0010, 4'b0010, 32'h0000_3300, 1'b0, 8'h0, 1'b1);
        #2;
        chk("fl_d_out_valid", 32'(out_valid), 32'h0);
        chk("fl_d_src_rd", 32'(src_rd), 32'b0000);
        tick();
        #2;
        chk("fl_e_out", 32'({out_valid, out_last, out_data}), 32'h333);
        chk("fl_e_grant", 32'(grant_id), 32'd1);
        chk("fl_e_src_rd", 32'(src_rd), 32'b0010);
        tick();

        // Reset mid-message of src3; src0 must win the next arbitration.
        do_reset();
        drive(4'b1000, 4'b0000, 32'h7700_0000, 1'b0, 8'h0, 1'b1);
        tick();
        #2;
        chk("rm_msg_out", 32'({out_valid, out_data}), 32'h177);
        chk("rm_msg_grant", 32'(grant_id), 32'd3);
        rst = 1'b1;
        rt_valid = 1'b1;
        rt_data  = 8'hFA;
        #1;
        chk("rm_rst_out_valid", 32'(out_valid), 32'h0);
        chk("rm_rst_rd", 32'({rt_rd, src_rd}), 32'h0);
        tick();
        rst = 1'b0;
        drive(4'b1001, 4'b1001, 32'h7700_0066, 1'b0, 8'h0, 1'b1);
        #2;
        chk("rm_busy", 32'(busy), 32'h0);
        chk("rm_idle_out_valid", 32'(out_valid), 32'h0);
        tick();
        #2;
        chk("rm_next_grant", 32'(grant_id), 32'd0);
        chk("rm_next_out", 32'({out_valid, out_data}), 32'h166);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
